// File: rtl/audio_i2s_pkg.sv
// audio_i2s_pkg: shared types and constants for the I2S receive path.
package audio_i2s_pkg;

  // Default sample width in bits
  localparam int unsigned AUDIO_I2S_DATA_W_DEFAULT  = 16;
  // Fewest synchronizer flops allowed on an asynchronous audio input
  localparam int unsigned AUDIO_I2S_SYNC_STAGES_MIN = 2;

  // Receiver framing state
  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_rx_state_t;

endpackage

// File: rtl/audio_sync_edge.sv
// audio_sync_edge: N-flop synchronizer for one asynchronous input, plus a
// delayed copy of the synchronized value used for rising-edge detection.
module audio_sync_edge
  import audio_i2s_pkg::*;
#(
  parameter int unsigned STAGES = AUDIO_I2S_SYNC_STAGES_MIN
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic sync,
  output logic rise
);

  // Depths below the minimum are not metastability-safe, so clamp them
  localparam int unsigned N = (STAGES < AUDIO_I2S_SYNC_STAGES_MIN) ?
                              AUDIO_I2S_SYNC_STAGES_MIN : STAGES;

  logic [N-1:0] chain_q;
  logic         dly_q;

  // Synchronizer chain followed by one extra flop for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= '0;
      dly_q   <= 1'b0;
    end else begin
      chain_q <= {chain_q[N-2:0], d_i};
      dly_q   <= chain_q[N-1];
    end
  end

  assign sync = chain_q[N-1];
  assign rise = chain_q[N-1] & ~dly_q;

endmodule

// File: rtl/audio_i2s_receiver.sv
// audio_i2s_receiver: oversampling I2S capture in the iCLK domain. Deframes
// one left/right pair per LRCK period and offers it on a valid/ready port.
// Optional feature: define AUDIO_I2S_RX_MONO_MIX_EN to add the oMONO output.
module audio_i2s_receiver
  import audio_i2s_pkg::*;
#(
  parameter int unsigned DATA_W      = AUDIO_I2S_DATA_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = AUDIO_I2S_SYNC_STAGES_MIN
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iAUD_BCK,
  input  logic              iAUD_LRCK,
  input  logic              iAUD_ADCDAT,
  output logic [DATA_W-1:0] oL,
  output logic [DATA_W-1:0] oR,
  output logic              oVALID,
  input  logic              iREADY,
  input  logic              iCLR,
  output logic              oOVERFLOW,
`ifdef AUDIO_I2S_RX_MONO_MIX_EN
  output logic [DATA_W-1:0] oMONO,
`endif
  output logic              oSYNC_ERR
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic bck_rise, lrck_s, dat_s;
  logic lrck_rise_unused, dat_rise_unused;

  audio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bck (
    .clk_i(iCLK), .rst_ni(iRST_N), .d_i(iAUD_BCK), .sync(), .rise(bck_rise)
  );
  audio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrck (
    .clk_i(iCLK), .rst_ni(iRST_N), .d_i(iAUD_LRCK), .sync(lrck_s), .rise(lrck_rise_unused)
  );
  audio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_dat (
    .clk_i(iCLK), .rst_ni(iRST_N), .d_i(iAUD_ADCDAT), .sync(dat_s), .rise(dat_rise_unused)
  );

  i2s_rx_state_t     state_q, state_d;
  logic              lrck_prev_q;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d, left_hold_q, left_hold_d;
  logic              left_ok_q, left_ok_d;
  logic [DATA_W-1:0] l_q, l_d, r_q, r_d;
  logic              valid_q, valid_d, ovf_q, ovf_d, err_q, err_d;

  // LRCK transitions as seen on BCK rises; such a rise carries the
  // previous slot's last bit, which is never captured
  logic lr_rise, lr_fall, capture, word_done, short_word;
  logic [DATA_W-1:0] word_in;
  logic slot_end, left_done, commit, can_load, load;

  assign lr_fall    = bck_rise &  lrck_prev_q & ~lrck_s;
  assign lr_rise    = bck_rise & ~lrck_prev_q &  lrck_s;
  assign capture    = bck_rise & (state_q != HUNT) & ~lr_rise & ~lr_fall &
                      (bit_cnt_q < CNT_FULL);
  assign word_done  = capture & (bit_cnt_q == CNT_LAST);
  assign short_word = bit_cnt_q < CNT_FULL;
  assign word_in    = {shift_q[DATA_W-2:0], dat_s};
  assign can_load   = ~valid_q | iREADY;
  assign load       = commit & can_load;

  // State register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= HUNT;
    else         state_q <= state_d;
  end

  // Next-state logic: slots follow the sampled LRCK level
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT:    if (lr_fall) state_d = LEFT;
      LEFT:    if (lr_rise) state_d = RIGHT;
      RIGHT:   if (lr_fall) state_d = LEFT;
      default: state_d = HUNT;
    endcase
  end

  // State-decoded strobes: end of slot, finished left word, pair commit
  always_comb begin
    slot_end  = 1'b0;
    left_done = 1'b0;
    commit    = 1'b0;
    unique case (state_q)
      LEFT: begin
        slot_end  = lr_rise;
        left_done = word_done;
      end
      RIGHT: begin
        slot_end = lr_fall;
        commit   = word_done & left_ok_q;
      end
      default: ;
    endcase
  end

  // Shift register, bit counter and the held left word
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    if (slot_end || (state_q == HUNT && lr_fall)) begin
      bit_cnt_d = '0;
    end else if (capture) begin
      shift_d   = word_in;
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end
    if (left_done) begin
      left_hold_d = word_in;
      left_ok_d   = 1'b1;
    end else if (slot_end && (state_q == RIGHT || short_word)) begin
      left_ok_d = 1'b0;
    end
  end

  // Output pair, handshake and sticky flags; a new error beats iCLR
  always_comb begin
    l_d     = l_q;
    r_d     = r_q;
    valid_d = valid_q;
    if (load) begin
      l_d     = left_hold_q;
      r_d     = word_in;
      valid_d = 1'b1;
    end else if (valid_q && iREADY) begin
      valid_d = 1'b0;
    end
    ovf_d = (ovf_q & ~iCLR) | (commit & ~can_load);
    err_d = (err_q & ~iCLR) | (slot_end & short_word);
  end

  // Datapath and output registers
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      lrck_prev_q <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      l_q         <= '0;
      r_q         <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (bck_rise) lrck_prev_q <= lrck_s;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      l_q         <= l_d;
      r_q         <= r_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

`ifdef AUDIO_I2S_RX_MONO_MIX_EN
  logic [DATA_W:0]   mono_sum;
  logic [DATA_W-1:0] mono_q, mono_d;
  // Sum in DATA_W+1 bits, then drop the LSB: arithmetic halve toward -inf
  assign mono_sum = {left_hold_q[DATA_W-1], left_hold_q} + {word_in[DATA_W-1], word_in};
  assign mono_d   = load ? mono_sum[DATA_W:1] : mono_q;

  // Mono mix register, loaded with the pair
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) mono_q <= '0;
    else         mono_q <= mono_d;
  end
  assign oMONO = mono_q;
`endif

  assign oL        = l_q;
  assign oR        = r_q;
  assign oVALID    = valid_q;
  assign oOVERFLOW = ovf_q;
  assign oSYNC_ERR = err_q;

endmodule

// File: tb/tb_audio_i2s_receiver.sv
// tb_audio_i2s_receiver: frame-level I2S stimulus with a pair/flag model.
`timescale 1ns/1ps
module tb_audio_i2s_receiver;
  localparam int W = 16;

  logic clk = 1'b0, rst_n = 1'b0, bck = 1'b0, lrck = 1'b0, dat = 1'b0;
  logic ready = 1'b0, clr = 1'b0;
  logic [W-1:0] o_l, o_r;
  logic o_valid, o_ovf, o_err;
`ifdef AUDIO_I2S_RX_MONO_MIX_EN
  logic [W-1:0] o_mono;
`endif

  always #10 clk = ~clk;

  audio_i2s_receiver #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iAUD_BCK(bck), .iAUD_LRCK(lrck),
    .iAUD_ADCDAT(dat), .oL(o_l), .oR(o_r), .oVALID(o_valid),
    .iREADY(ready), .iCLR(clr), .oOVERFLOW(o_ovf),
`ifdef AUDIO_I2S_RX_MONO_MIX_EN
    .oMONO(o_mono),
`endif
    .oSYNC_ERR(o_err)
  );

  typedef struct packed { logic [W-1:0] l; logic [W-1:0] r; } pair_t;
  typedef struct { logic [W-1:0] l; logic [W-1:0] r; int nl; int nr; bit pair; bit err; } vec_t;

  pair_t exp_q[$];
  int n_checks = 0, n_pass = 0, valid_cycles = 0, accepts = 0;
  int arm_mode = 0;
  event ev_arm;
  logic carry = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Monitor: every accepted pair must be the next one the model expects
  always @(negedge clk) begin
    pair_t e;
    int s;
    logic [W-1:0] em;
    if (rst_n) begin
      if (o_valid) valid_cycles++;
      if (o_valid && ready) begin
        accepts++;
        if (exp_q.size() == 0) check("unexpected_pair", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("pair_L", 32'(o_l), 32'(e.l));
          check("pair_R", 32'(o_r), 32'(e.r));
          s  = int'($signed(e.l)) + int'($signed(e.r));
          em = W'((s - ((s % 2 + 2) % 2)) / 2);
`ifdef AUDIO_I2S_RX_MONO_MIX_EN
          check("pair_MONO", 32'(o_mono), 32'(em));
`else
          if (em === 'x) $display("unreachable");
`endif
        end
      end
    end
  end

  function automatic logic bit_of(input logic [W-1:0] w, input int k);
    return (k < W) ? w[W-1-k] : 1'b0;
  endfunction

  // One LRCK period: first bit is the previous slot's last bit (I2S delay)
  task automatic send_slot(input logic lr, input logic [W-1:0] w, input int n, input int arm_j);
    for (int j = 0; j < n; j++) begin
      lrck = lr;
      dat  = (j == 0) ? carry : bit_of(w, j - 1);
      #160 bck = 1'b1;
      if (j == arm_j) -> ev_arm;
      #160 bck = 1'b0;
    end
    carry = bit_of(w, n - 1);
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                            input int nl, input int nr, input int arm_j, input int jit);
    @(posedge clk);
    #(5 + jit);
    send_slot(1'b0, l, nl, -1);
    send_slot(1'b1, r, nr, arm_j);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic do_clear();
    @(posedge clk); #2 clr = 1'b1;
    @(posedge clk); #2 clr = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] l, input logic [W-1:0] r);
    pair_t p;
    p.l = l; p.r = r;
    exp_q.push_back(p);
  endtask

  // Armed actions timed from a chosen right-slot BCK rise
  initial forever begin
    @(ev_arm);
    if (arm_mode == 1) begin
      repeat (2) @(posedge clk);
      #2 ready = 1'b1;
      @(posedge clk);
      #2 ready = 1'b0;
    end else if (arm_mode == 2) begin
      #7 rst_n = 1'b0;
      #1;
      check("rmw_L_now", 32'(o_l), 32'd0);
      check("rmw_R_now", 32'(o_r), 32'd0);
      check("rmw_valid_now", 32'(o_valid), 32'd0);
      check("rmw_ovf_now", 32'(o_ovf), 32'd0);
      check("rmw_err_now", 32'(o_err), 32'd0);
      #100 rst_n = 1'b1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int a0, v0, nl, nr;
    logic [W-1:0] l, r;
    bit prev_rs, exp_err;

    vt[0] = '{16'h8001, 16'h7FFE, 32, 32, 1'b1, 1'b0};
    vt[1] = '{16'h0F0F, 16'hF0F0, 32, 32, 1'b1, 1'b0};
    vt[2] = '{16'h1111, 16'h2222, 10, 32, 1'b0, 1'b1};  // short left
    vt[3] = '{16'h0F0F, 16'hF0F0, 17, 17, 1'b1, 1'b0};  // shortest legal slots
    vt[4] = '{16'hAAAA, 16'h5555, 32, 16, 1'b0, 1'b0};  // short right, flagged next slot
    vt[5] = '{16'h0000, 16'hFFFF, 32, 32, 1'b1, 1'b1};

    repeat (5) @(posedge clk);
    #2;
    check("rst_L", 32'(o_l), 32'd0);
    check("rst_R", 32'(o_r), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ovf", 32'(o_ovf), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    #5 rst_n = 1'b1;
    ready = 1'b1;
    send_slot(1'b1, '0, 32, -1);

    for (int i = 0; i < 6; i++) begin
      if (vt[i].pair) push(vt[i].l, vt[i].r);
      a0 = accepts; v0 = valid_cycles;
      send_frame(vt[i].l, vt[i].r, vt[i].nl, vt[i].nr, -1, 0);
      settle();
      check($sformatf("vec%0d_pairs", i), 32'(accepts - a0), 32'(vt[i].pair));
      check($sformatf("vec%0d_pulse", i), 32'(valid_cycles - v0), 32'(vt[i].pair));
      check($sformatf("vec%0d_err", i), 32'(o_err), 32'(vt[i].err));
      check($sformatf("vec%0d_ovf", i), 32'(o_ovf), 32'd0);
      check($sformatf("vec%0d_pending", i), 32'(exp_q.size()), 32'd0);
      do_clear();
    end

    // Random frames; a slot holds DATA_W bits only if its LRCK period exceeds DATA_W
    prev_rs = 1'b0;
    for (int k = 0; k < 11; k++) begin
      l  = W'($urandom);
      r  = W'($urandom);
      nl = (k == 10) ? 32 : int'($urandom_range(14, 32));
      nr = (k == 10) ? 32 : int'($urandom_range(14, 32));
      exp_err = (nl <= W) || prev_rs;
      if (nl > W && nr > W) push(l, r);
      a0 = accepts;
      send_frame(l, r, nl, nr, -1, int'($urandom_range(0, 13)));
      settle();
      check($sformatf("rnd%0d_pairs", k), 32'(accepts - a0), 32'(nl > W && nr > W));
      check($sformatf("rnd%0d_err", k), 32'(o_err), 32'(exp_err));
      prev_rs = (nr <= W);
      do_clear();
    end

    // Backpressure across two frames
    ready = 1'b0;
    send_frame(16'h1234, 16'h5678, 32, 32, -1, 0);
    settle();
    check("bp_valid_a", 32'(o_valid), 32'd1);
    check("bp_ovf_a", 32'(o_ovf), 32'd0);
    send_frame(16'h9ABC, 16'hDEF0, 32, 32, -1, 0);
    settle();
    check("bp_L", 32'(o_l), 32'h1234);
    check("bp_R", 32'(o_r), 32'h5678);
    check("bp_ovf", 32'(o_ovf), 32'd1);
    push(16'h1234, 16'h5678);
    ready = 1'b1;
    settle();
    check("bp_drained", 32'(o_valid), 32'd0);
    check("bp_ovf_held", 32'(o_ovf), 32'd1);
    do_clear();
    #2 check("bp_ovf_clr", 32'(o_ovf), 32'd0);

    // Accept of the old pair on the very edge that commits the new one
    ready = 1'b0;
    send_frame(16'h1111, 16'h2222, 32, 32, -1, 0);
    settle();
    check("sim_valid_pre", 32'(o_valid), 32'd1);
    push(16'h1111, 16'h2222);
    push(16'h3333, 16'h4444);
    arm_mode = 1;
    send_frame(16'h3333, 16'h4444, 32, 32, 16, 0);
    arm_mode = 0;
    settle();
    check("sim_valid", 32'(o_valid), 32'd1);
    check("sim_L", 32'(o_l), 32'h3333);
    check("sim_R", 32'(o_r), 32'h4444);
    check("sim_ovf", 32'(o_ovf), 32'd0);
    check("sim_pending", 32'(exp_q.size()), 32'd1);
    ready = 1'b1;
    settle();
    check("sim_drained", 32'(exp_q.size()), 32'd0);

    // Reset released partway through a right word
    rst_n = 1'b0;
    #3;
    send_slot(1'b1, W'($urandom), 6, -1);
    #37 rst_n = 1'b1;
    send_slot(1'b1, W'($urandom), 20, -1);
    push(16'h4321, 16'h8765);
    a0 = accepts;
    send_frame(16'h4321, 16'h8765, 32, 32, -1, 0);
    settle();
    check("mid_pairs", 32'(accepts - a0), 32'd1);
    check("mid_err", 32'(o_err), 32'd0);
    check("mid_pending", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset during right bit 7 with a pair still held
    ready = 1'b0;
    send_frame(16'h5A5A, 16'hA5A5, 32, 32, -1, 0);
    settle();
    check("rmw_valid_pre", 32'(o_valid), 32'd1);
    arm_mode = 2;
    send_frame(16'hC3C3, 16'h3C3C, 32, 32, 8, 0);
    arm_mode = 0;
    ready = 1'b1;
    push(16'h0F0F, 16'hF0F0);
    a0 = accepts;
    send_frame(16'h0F0F, 16'hF0F0, 32, 32, -1, 0);
    settle();
    check("rmw_pairs", 32'(accepts - a0), 32'd1);
    check("rmw_err", 32'(o_err), 32'd0);
    check("rmw_ovf", 32'(o_ovf), 32'd0);
    check("rmw_pending", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
